// File: rtl/mmio_pkg.sv
// Shared address-field layout and read-source encoding for the MMIO register bank.
package mmio_pkg;

  localparam int MMIO_SEL_BIT    = 12;
  localparam int CH_LSB          = 7;
  localparam int CH_BITS         = 5;
  localparam int REG_LSB         = 2;
  localparam int REG_BITS        = 5;
  localparam int REG_STATUS_IDX  = 31;
  localparam int REG_PENDING_IDX = 30;

  typedef logic [CH_BITS-1:0]  ch_idx_t;
  typedef logic [REG_BITS-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RD_NONE    = 2'd0,
    RD_SHADOW  = 2'd1,
    RD_STATUS  = 2'd2,
    RD_PENDING = 2'd3
  } rd_src_t;

endpackage

// File: rtl/mmio_regbank_if.sv
// CPU memory-port bundle. Requests (wren/rden) are single-cycle strobes with no
// back-pressure; a read answers with rd_valid exactly one cycle after rden.
interface mmio_regbank_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wren;
  logic                  rden;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  dmem_wren;

  modport master (
    output address, data_in, wren, rden,
    input  data_out, rd_valid, dmem_wren
  );

  modport slave (
    input  address, data_in, wren, rden,
    output data_out, rd_valid, dmem_wren
  );
endinterface

// File: rtl/mmio_channel.sv
// One coprocessor channel: shadow/active register copies, pending flag and the
// one-cycle applied pulse. IMMEDIATE channels write both copies at once.
module mmio_channel
  import mmio_pkg::*;
#(
  parameter int REGS      = 8,
  parameter int DW        = 32,
  parameter bit IMMEDIATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr_hit,
  input  reg_idx_t         i_wr_reg,
  input  logic [DW-1:0]    i_wr_data,
  input  logic             i_commit,
  output logic [REGS*DW-1:0] o_active,
  output logic [REGS*DW-1:0] o_shadow,
  output logic             o_pending,
  output logic             o_applied
);

  logic [DW-1:0] r_shadow [REGS];
  logic [DW-1:0] r_active [REGS];
  logic          r_pending;
  logic          r_applied;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < REGS; r++) begin
        r_shadow[r] <= '0;
        r_active[r] <= '0;
      end
      r_pending <= 1'b0;
      r_applied <= 1'b0;
    end else begin
      r_applied <= 1'b0;
      if (IMMEDIATE) begin
        if (i_wr_hit) begin
          for (int r = 0; r < REGS; r++) begin
            if (i_wr_reg == REG_BITS'(r)) begin
              r_shadow[r] <= i_wr_data;
              r_active[r] <= i_wr_data;
            end
          end
          r_applied <= 1'b1;
        end
      end else begin
        // Commit copies the pre-edge shadow; a same-cycle write re-arms pending.
        if (i_commit && r_pending) begin
          for (int r = 0; r < REGS; r++) r_active[r] <= r_shadow[r];
          r_applied <= 1'b1;
          r_pending <= 1'b0;
        end
        if (i_wr_hit) begin
          for (int r = 0; r < REGS; r++) begin
            if (i_wr_reg == REG_BITS'(r)) r_shadow[r] <= i_wr_data;
          end
          r_pending <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < REGS; g++) begin : g_flat
    assign o_active[g*DW +: DW] = r_active[g];
    assign o_shadow[g*DW +: DW] = r_shadow[g];
  end

  assign o_pending = r_pending;
  assign o_applied = r_applied;

endmodule

// File: rtl/mmio_regbank.sv
// Double-buffered MMIO register bank: address decode, per-channel storage and a
// registered one-cycle read path; non-MMIO writes are steered to dmem.
module mmio_regbank
  import mmio_pkg::*;
#(
  parameter int NUM_CHANNELS     = 16,
  parameter int REGS_PER_CHANNEL = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 13,
  parameter logic [NUM_CHANNELS-1:0] IMMEDIATE_MASK = '0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  mmio_regbank_if.slave                                bus,
  input  logic                                         commit,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]           status_in,
  output logic [NUM_CHANNELS*REGS_PER_CHANNEL*DATA_WIDTH-1:0] cfg_out,
  output logic [NUM_CHANNELS-1:0]                      applied,
  output logic [NUM_CHANNELS-1:0]                      pending
);

  localparam int CH_W = REGS_PER_CHANNEL * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_mmio;
  ch_idx_t               w_ch;
  reg_idx_t              w_reg;
  logic                  w_ch_ok;
  logic                  w_reg_ok;
  logic                  w_wr_hit;
  logic                  w_unused_addr;
  logic [NUM_CHANNELS*CH_W-1:0] w_shadow;
  logic [DATA_WIDTH-1:0] w_pending_ext;
  rd_src_t               w_rd_src;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rd_valid;

  assign w_addr        = bus.address;
  assign w_mmio        = w_addr[MMIO_SEL_BIT];
  assign w_ch          = w_addr[CH_LSB +: CH_BITS];
  assign w_reg         = w_addr[REG_LSB +: REG_BITS];
  assign w_unused_addr = ^w_addr;
  assign w_ch_ok       = 32'(w_ch) < NUM_CHANNELS;
  assign w_reg_ok      = 32'(w_reg) < REGS_PER_CHANNEL;
  assign w_wr_hit      = bus.wren & w_mmio & w_ch_ok & w_reg_ok;
  assign w_pending_ext = DATA_WIDTH'(pending);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mmio_channel #(
      .REGS      (REGS_PER_CHANNEL),
      .DW        (DATA_WIDTH),
      .IMMEDIATE (IMMEDIATE_MASK[c])
    ) u_channel (
      .clock     (clock),
      .reset     (reset),
      .i_wr_hit  (w_wr_hit && (w_ch == CH_BITS'(c))),
      .i_wr_reg  (w_reg),
      .i_wr_data (bus.data_in),
      .i_commit  (commit),
      .o_active  (cfg_out[c*CH_W +: CH_W]),
      .o_shadow  (w_shadow[c*CH_W +: CH_W]),
      .o_pending (pending[c]),
      .o_applied (applied[c])
    );
  end

  always_comb begin
    w_rd_src = RD_NONE;
    if (w_ch_ok) begin
      if (w_reg_ok)                                   w_rd_src = RD_SHADOW;
      else if (w_reg == REG_BITS'(REG_STATUS_IDX))    w_rd_src = RD_STATUS;
      else if (w_reg == REG_BITS'(REG_PENDING_IDX))   w_rd_src = RD_PENDING;
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_ch == CH_BITS'(c)) begin
        case (w_rd_src)
          RD_SHADOW: begin
            for (int r = 0; r < REGS_PER_CHANNEL; r++) begin
              if (w_reg == REG_BITS'(r))
                w_rd_data = w_shadow[(c*REGS_PER_CHANNEL + r)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          RD_STATUS:  w_rd_data = status_in[c*DATA_WIDTH +: DATA_WIDTH];
          RD_PENDING: w_rd_data = w_pending_ext;
          default:    w_rd_data = '0;
        endcase
      end
    end
  end

  // Non-MMIO reads belong to dmem, so data_out keeps its last MMIO value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rden & w_mmio;
      if (bus.rden & w_mmio) r_data_out <= w_rd_data;
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.dmem_wren = bus.wren & ~w_mmio;

endmodule

// File: tb/tb_mmio_regbank.sv
// Directed and randomized bench for mmio_regbank, scored against an array-based
// model of the shadow/active/pending behaviour.
module tb_mmio_regbank;

  localparam int N  = 16;
  localparam int R  = 8;
  localparam int DW = 32;
  localparam int AW = 13;
  localparam logic [N-1:0] IMM = 16'h0004;

  logic clock;
  logic reset;
  logic commit;
  logic [N*DW-1:0]   status_in;
  logic [N*R*DW-1:0] cfg_out;
  logic [N-1:0]      applied;
  logic [N-1:0]      pending;

  mmio_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mmio_regbank #(
    .NUM_CHANNELS(N), .REGS_PER_CHANNEL(R), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .IMMEDIATE_MASK(IMM)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .commit(commit),
    .status_in(status_in), .cfg_out(cfg_out), .applied(applied), .pending(pending)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // reference model state
  logic [DW-1:0] m_shadow [N][R];
  logic [DW-1:0] m_active [N][R];
  logic [N-1:0]  m_pending;
  logic [N-1:0]  m_applied;
  logic [DW-1:0] m_dout;
  logic          m_rdv;
  logic [DW-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int a, ch, rg;
    bit mmio;
    logic [DW-1:0] rv;
    a    = int'(bus.address);
    mmio = (a / 4096) == 1;
    ch   = (a / 128) % 32;
    rg   = (a / 4) % 32;
    if (reset) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < R; r++) begin
          m_shadow[c][r] = '0;
          m_active[c][r] = '0;
        end
      m_pending = '0; m_applied = '0; m_dout = '0; m_rdv = 1'b0;
      exp_q.delete();
      return;
    end
    rv = '0;
    if (ch < N) begin
      if (rg < R)        rv = m_shadow[ch][rg];
      else if (rg == 31) rv = status_in[ch*DW +: DW];
      else if (rg == 30) rv = DW'(m_pending);
    end
    m_applied = '0;
    if (commit)
      for (int c = 0; c < N; c++)
        if (!IMM[c] && m_pending[c]) begin
          for (int r = 0; r < R; r++) m_active[c][r] = m_shadow[c][r];
          m_pending[c] = 1'b0;
          m_applied[c] = 1'b1;
        end
    if (bus.wren && mmio && ch < N && rg < R) begin
      m_shadow[ch][rg] = bus.data_in;
      if (IMM[ch]) begin
        m_active[ch][rg] = bus.data_in;
        m_applied[ch] = 1'b1;
      end else begin
        m_pending[ch] = 1'b1;
      end
    end
    if (bus.rden && mmio) exp_q.push_back(rv);
    m_rdv = bus.rden && mmio;
    if (m_rdv) m_dout = exp_q.pop_front();
  endtask

  task automatic check_all();
    logic exp_dmem;
    exp_dmem = bus.wren && (int'(bus.address) < 4096);
    check_val("rd_valid", DW'(bus.rd_valid), DW'(m_rdv));
    check_val("data_out", bus.data_out, m_dout);
    check_val("applied", DW'(applied), DW'(m_applied));
    check_val("pending", DW'(pending), DW'(m_pending));
    check_val("dmem_wren", DW'(bus.dmem_wren), DW'(exp_dmem));
    for (int c = 0; c < N; c++)
      for (int r = 0; r < R; r++)
        check_val($sformatf("cfg ch%0d r%0d", c, r), cfg_out[(c*R + r)*DW +: DW], m_active[c][r]);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic wr, input logic rd, input logic cm,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wren = wr; bus.rden = rd; commit = cm;
    bus.address = addr; bus.data_in = data;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int ch, rg;
    logic [4:0] chb, rgb;
    logic [1:0] lo;
    logic mmio;
    ch = $urandom_range(0, 19);
    rg = $urandom_range(0, 11);
    if (rg == 10) rg = 30;
    if (rg == 11) rg = 31;
    chb  = ch[4:0];
    rgb  = rg[4:0];
    lo   = 2'($urandom_range(0, 3));
    mmio = ($urandom_range(0, 9) != 0);
    return {mmio, chb, rgb, lo};
  endfunction

  initial begin
    reset = 1'b1; commit = 1'b0; status_in = '0;
    bus.wren = 1'b0; bus.rden = 1'b0; bus.address = '0; bus.data_in = '0;
    step();
    step();
    reset = 1'b0;
    check_val("reset cfg ch0r0", cfg_out[DW-1:0], 32'h0);
    check_val("reset pending", DW'(pending), 32'h0);

    // shadow write without commit, then read it back
    drive(1'b1, 1'b0, 1'b0, 13'h1000, 32'h0000_0010);
    check_val("uncommitted active", cfg_out[DW-1:0], 32'h0);
    check_val("pending0 set", DW'(pending[0]), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 13'h1000, '0);
    check_val("read shadow valid", DW'(bus.rd_valid), 32'h1);
    check_val("read shadow data", bus.data_out, 32'h10);

    // commit, then a redundant commit
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check_val("commit active", cfg_out[DW-1:0], 32'h10);
    check_val("commit applied0", DW'(applied[0]), 32'h1);
    check_val("commit pending0", DW'(pending[0]), 32'h0);
    check_val("rd_valid drops", DW'(bus.rd_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check_val("second commit no pulse", DW'(applied), 32'h0);

    // write + commit same cycle on a pending channel
    drive(1'b1, 1'b0, 1'b0, 13'h1088, 32'h55);
    drive(1'b1, 1'b0, 1'b1, 13'h1088, 32'hAA);
    check_val("wr+commit active", cfg_out[(1*R + 2)*DW +: DW], 32'h55);
    check_val("wr+commit pending1", DW'(pending[1]), 32'h1);
    check_val("wr+commit applied1", DW'(applied[1]), 32'h1);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check_val("next commit active", cfg_out[(1*R + 2)*DW +: DW], 32'hAA);

    // immediate channel
    drive(1'b1, 1'b0, 1'b0, 13'h110C, 32'h0160_00FA);
    check_val("imm active", cfg_out[(2*R + 3)*DW +: DW], 32'h0160_00FA);
    check_val("imm applied2", DW'(applied[2]), 32'h1);
    check_val("imm pending2", DW'(pending[2]), 32'h0);

    // status, pending vector and out-of-range reads
    status_in[12*DW +: DW] = 32'h3;
    drive(1'b0, 1'b1, 1'b0, 13'h167C, '0);
    check_val("status ch12", bus.data_out, 32'h3);
    drive(1'b1, 1'b0, 1'b0, 13'h1004, 32'h1234);
    drive(1'b0, 1'b1, 1'b0, 13'h1078, '0);
    check_val("pending vector", bus.data_out, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 13'h1A00, '0);
    check_val("ch20 read", bus.data_out, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 13'h0040, 32'hDEAD);
    check_val("dmem_wren", DW'(bus.dmem_wren), 32'h1);

    // reset discards pending writes and an in-flight read
    drive(1'b1, 1'b0, 1'b0, 13'h1180, 32'h77);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 13'h1180, '0);
    reset = 1'b0;
    check_val("reset pending", DW'(pending), 32'h0);
    check_val("reset rd_valid", DW'(bus.rd_valid), 32'h0);
    check_val("reset data_out", bus.data_out, 32'h0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    check_val("discarded write", cfg_out[(3*R)*DW +: DW], 32'h0);
    check_val("no applied after reset", DW'(applied), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) status_in[c*DW +: DW] = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), rand_addr(), $urandom);
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
